// File: rtl/countdown_pkg.sv
// Shared types and constants for the round-start countdown overlay sequencer.
package countdown_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ARMED,
    CNT3,
    CNT2,
    CNT1,
    FIGHT,
    DONE
  } cd_state_t;

  typedef logic [1:0] sprite_t;

  localparam sprite_t SPR_THREE = 2'd0;
  localparam sprite_t SPR_TWO   = 2'd1;
  localparam sprite_t SPR_ONE   = 2'd2;
  localparam sprite_t SPR_FIGHT = 2'd3;

  // A hold length of N frames needs the counter to reach N-1 without wrapping.
  function automatic bit cnt_fits(input int cnt_w, input int frames);
    return (frames >= 1) && ((frames - 1) < (1 << cnt_w));
  endfunction

  function automatic sprite_t sprite_of(input cd_state_t s);
    case (s)
      CNT2:    return SPR_TWO;
      CNT1:    return SPR_ONE;
      FIGHT:   return SPR_FIGHT;
      default: return SPR_THREE;
    endcase
  endfunction

endpackage

// File: rtl/countdown_sequencer_if.sv
// Control/status bundle between game logic and the countdown sequencer.
interface countdown_sequencer_if;
  import countdown_pkg::*;

  logic    vsync;
  logic    start;
  logic    abort;
  logic    pause;
  sprite_t sprite_sel;
  logic    overlay_en;
  logic    busy;
  logic    fight_go;
  logic    round_active;

  modport master (
    output vsync, start, abort, pause,
    input  sprite_sel, overlay_en, busy, fight_go, round_active
  );

  modport slave (
    input  vsync, start, abort, pause,
    output sprite_sel, overlay_en, busy, fight_go, round_active
  );

endinterface

// File: rtl/frame_tick_gen.sv
// Registered vsync active-edge detector; one-cycle frame_tick, one cycle after the edge.
module frame_tick_gen #(
  parameter bit VSYNC_ACT_LOW = 1'b1
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_vsync,
  output logic o_frame_tick
);

  logic r_vsync_d;
  logic r_tick;
  logic w_act_now;
  logic w_act_prev;

  assign w_act_now  = i_vsync   ^ VSYNC_ACT_LOW;
  assign w_act_prev = r_vsync_d ^ VSYNC_ACT_LOW;

  // History resets to the inactive level so a held-active vsync at release is not an edge.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_vsync_d <= VSYNC_ACT_LOW;
      r_tick    <= 1'b0;
    end else begin
      r_vsync_d <= i_vsync;
      r_tick    <= w_act_now & ~w_act_prev;
    end
  end

  assign o_frame_tick = r_tick;

endmodule

// File: rtl/countdown_sequencer.sv
// Round-start countdown: 3 -> 2 -> 1 -> FIGHT overlay, each step held a fixed number of frames,
// with all sprite changes landing on frame boundaries.
module countdown_sequencer
  import countdown_pkg::*;
#(
  parameter int FRAMES_PER_DIGIT = 60,
  parameter int FIGHT_FRAMES     = 45,
  parameter int CNT_W            = 8,
  parameter int VSYNC_ACT_LOW    = 1
) (
  input  logic                  vga_clk,
  input  logic                  reset_n,
  countdown_sequencer_if.slave  bus
);

  if (!cnt_fits(CNT_W, FRAMES_PER_DIGIT) || !cnt_fits(CNT_W, FIGHT_FRAMES)) begin : g_cnt_w_check
    $error("countdown_sequencer: CNT_W too narrow or frame count < 1");
  end

  localparam logic [CNT_W-1:0] L_DIGIT_LAST = CNT_W'(FRAMES_PER_DIGIT - 1);
  localparam logic [CNT_W-1:0] L_FIGHT_LAST = CNT_W'(FIGHT_FRAMES - 1);

  logic [1:0]       r_rst_sync;
  logic             w_rst_n;
  logic             w_frame_tick;
  cd_state_t        r_state;
  cd_state_t        w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  sprite_t          r_sprite_sel;
  logic             r_overlay_en;
  logic             r_busy;
  logic             r_fight_go;
  logic             r_round_active;

  // Reset asserts asynchronously, releases on a clock edge.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) r_rst_sync <= 2'b00;
    else          r_rst_sync <= {r_rst_sync[0], 1'b1};
  end

  assign w_rst_n = r_rst_sync[1];

  frame_tick_gen #(
    .VSYNC_ACT_LOW (VSYNC_ACT_LOW != 0)
  ) u_frame_tick_gen (
    .i_clk        (vga_clk),
    .i_rst_n      (w_rst_n),
    .i_vsync      (bus.vsync),
    .o_frame_tick (w_frame_tick)
  );

  // Abort outranks start; start outranks a coincident tick so the tick is not consumed.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    if (bus.abort) begin
      w_state_nxt = IDLE;
      w_cnt_nxt   = '0;
    end else if (bus.start) begin
      w_state_nxt = ARMED;
      w_cnt_nxt   = '0;
    end else if (w_frame_tick && !bus.pause) begin
      case (r_state)
        ARMED: begin
          w_state_nxt = CNT3;
          w_cnt_nxt   = '0;
        end
        CNT3, CNT2, CNT1: begin
          if (r_cnt == L_DIGIT_LAST) begin
            w_cnt_nxt   = '0;
            w_state_nxt = (r_state == CNT3) ? CNT2 :
                          (r_state == CNT2) ? CNT1 : FIGHT;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
        FIGHT: begin
          if (r_cnt == L_FIGHT_LAST) begin
            w_cnt_nxt   = '0;
            w_state_nxt = DONE;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // State, counter and Moore outputs decoded from the next state, all registered together.
  always_ff @(posedge vga_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state        <= IDLE;
      r_cnt          <= '0;
      r_sprite_sel   <= SPR_THREE;
      r_overlay_en   <= 1'b0;
      r_busy         <= 1'b0;
      r_fight_go     <= 1'b0;
      r_round_active <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_cnt          <= w_cnt_nxt;
      r_sprite_sel   <= sprite_of(w_state_nxt);
      r_overlay_en   <= w_state_nxt inside {CNT3, CNT2, CNT1, FIGHT};
      r_busy         <= w_state_nxt inside {ARMED, CNT3, CNT2, CNT1, FIGHT};
      r_fight_go     <= (r_state == CNT1) && (w_state_nxt == FIGHT);
      r_round_active <= w_state_nxt inside {FIGHT, DONE};
    end
  end

  assign bus.sprite_sel   = r_sprite_sel;
  assign bus.overlay_en   = r_overlay_en;
  assign bus.busy         = r_busy;
  assign bus.fight_go     = r_fight_go;
  assign bus.round_active = r_round_active;

endmodule

// File: tb/tb_countdown_sequencer.sv
// Directed bench for countdown_sequencer with FRAMES_PER_DIGIT=3, FIGHT_FRAMES=2, low-active vsync.
module tb_countdown_sequencer;

  logic clk;
  logic reset_n;
  int   checks   = 0;
  int   failures = 0;
  int   fg_cnt   = 0;

  logic [1:0] seq_sel [0:11] = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1,
                                 2'd2, 2'd2, 2'd2, 2'd3, 2'd3, 2'd0};

  countdown_sequencer_if cd_if ();

  countdown_sequencer #(
    .FRAMES_PER_DIGIT (3),
    .FIGHT_FRAMES     (2),
    .CNT_W            (8),
    .VSYNC_ACT_LOW    (1)
  ) dut (
    .vga_clk (clk),
    .reset_n (reset_n),
    .bus     (cd_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (cd_if.fight_go === 1'b1) fg_cnt <= fg_cnt + 1;

  initial begin
    #300000;
    $display("FAIL timeout: bench exceeded its time bound");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One vsync low pulse; returns once the resulting tick has been applied by the FSM.
  task automatic do_frame();
    cd_if.vsync = 1'b0;
    step();
    cd_if.vsync = 1'b1;
    step();
    step();
  endtask

  task automatic pulse_start();
    cd_if.start = 1'b1;
    step();
    cd_if.start = 1'b0;
    step();
  endtask

  task automatic test_reset();
    cd_if.vsync = 1'b1;
    cd_if.start = 1'b0;
    cd_if.abort = 1'b0;
    cd_if.pause = 1'b0;
    reset_n     = 1'b0;
    repeat (3) step();
    for (int i = 0; i < 6; i++) begin
      cd_if.vsync = ~cd_if.vsync;
      cd_if.start = ~cd_if.start;
      step();
    end
    checks++;
    if ({cd_if.sprite_sel, cd_if.overlay_en, cd_if.busy, cd_if.fight_go, cd_if.round_active} !== 6'b0) begin
      failures++;
      $display("FAIL reset_held: outputs=%b expected 000000",
               {cd_if.sprite_sel, cd_if.overlay_en, cd_if.busy, cd_if.fight_go, cd_if.round_active});
    end
    cd_if.vsync = 1'b1;
    cd_if.start = 1'b0;
    step();
    reset_n = 1'b1;
    repeat (3) step();
    checks++;
    if ({cd_if.sprite_sel, cd_if.overlay_en, cd_if.busy, cd_if.fight_go, cd_if.round_active} !== 6'b0) begin
      failures++;
      $display("FAIL reset_release: outputs=%b expected 000000",
               {cd_if.sprite_sel, cd_if.overlay_en, cd_if.busy, cd_if.fight_go, cd_if.round_active});
    end
    do_frame();
    checks++;
    if (cd_if.busy !== 1'b0 || cd_if.overlay_en !== 1'b0) begin
      failures++;
      $display("FAIL idle_ignores_tick: busy=%b overlay_en=%b expected 0 0", cd_if.busy, cd_if.overlay_en);
    end
  endtask

  task automatic test_sequence();
    int fg0;
    pulse_start();
    checks++;
    if (cd_if.busy !== 1'b1 || cd_if.overlay_en !== 1'b0) begin
      failures++;
      $display("FAIL armed: busy=%b overlay_en=%b expected 1 0", cd_if.busy, cd_if.overlay_en);
    end
    fg0 = fg_cnt;
    for (int i = 1; i <= 12; i++) begin
      do_frame();
      checks++;
      if (cd_if.sprite_sel !== seq_sel[i-1]) begin
        failures++;
        $display("FAIL seq_sel tick %0d: got %0d expected %0d", i, cd_if.sprite_sel, seq_sel[i-1]);
      end
      checks++;
      if (fg_cnt !== ((i >= 10) ? fg0 + 1 : fg0)) begin
        failures++;
        $display("FAIL seq_fight_go tick %0d: pulses=%0d expected %0d", i, fg_cnt - fg0, (i >= 10) ? 1 : 0);
      end
    end
    checks++;
    if (cd_if.round_active !== 1'b1 || cd_if.overlay_en !== 1'b0 || cd_if.busy !== 1'b0) begin
      failures++;
      $display("FAIL done_outputs: round_active=%b overlay_en=%b busy=%b expected 1 0 0",
               cd_if.round_active, cd_if.overlay_en, cd_if.busy);
    end
  endtask

  task automatic test_pause();
    pulse_start();
    repeat (5) do_frame();
    checks++;
    if (cd_if.sprite_sel !== 2'd1) begin
      failures++;
      $display("FAIL pause_pre: sprite_sel=%0d expected 1", cd_if.sprite_sel);
    end
    cd_if.pause = 1'b1;
    for (int i = 0; i < 5; i++) do_frame();
    checks++;
    if (cd_if.sprite_sel !== 2'd1 || cd_if.busy !== 1'b1) begin
      failures++;
      $display("FAIL pause_hold: sprite_sel=%0d busy=%b expected 1 1", cd_if.sprite_sel, cd_if.busy);
    end
    cd_if.pause = 1'b0;
    do_frame();
    checks++;
    if (cd_if.sprite_sel !== 2'd1) begin
      failures++;
      $display("FAIL pause_resume1: sprite_sel=%0d expected 1", cd_if.sprite_sel);
    end
    do_frame();
    checks++;
    if (cd_if.sprite_sel !== 2'd2) begin
      failures++;
      $display("FAIL pause_resume2: sprite_sel=%0d expected 2", cd_if.sprite_sel);
    end
  endtask

  task automatic test_abort_restart();
    int fg0;
    pulse_start();
    repeat (7) do_frame();
    checks++;
    if (cd_if.sprite_sel !== 2'd2) begin
      failures++;
      $display("FAIL abort_pre_cnt1: sprite_sel=%0d expected 2", cd_if.sprite_sel);
    end
    fg0 = fg_cnt;
    cd_if.start = 1'b1;
    cd_if.abort = 1'b1;
    step();
    cd_if.start = 1'b0;
    cd_if.abort = 1'b0;
    step();
    checks++;
    if (cd_if.busy !== 1'b0 || cd_if.overlay_en !== 1'b0 || cd_if.sprite_sel !== 2'd0) begin
      failures++;
      $display("FAIL abort_beats_start: busy=%b overlay_en=%b sel=%0d expected 0 0 0",
               cd_if.busy, cd_if.overlay_en, cd_if.sprite_sel);
    end
    repeat (4) do_frame();
    checks++;
    if (fg_cnt !== fg0 || cd_if.busy !== 1'b0) begin
      failures++;
      $display("FAIL abort_no_fight_go: pulses=%0d busy=%b expected 0 0", fg_cnt - fg0, cd_if.busy);
    end
    pulse_start();
    repeat (10) do_frame();
    checks++;
    if (cd_if.round_active !== 1'b1 || cd_if.sprite_sel !== 2'd3) begin
      failures++;
      $display("FAIL fight_reached: round_active=%b sel=%0d expected 1 3", cd_if.round_active, cd_if.sprite_sel);
    end
    pulse_start();
    checks++;
    if (cd_if.round_active !== 1'b0 || cd_if.busy !== 1'b1 || cd_if.overlay_en !== 1'b0) begin
      failures++;
      $display("FAIL restart_in_fight: round_active=%b busy=%b overlay_en=%b expected 0 1 0",
               cd_if.round_active, cd_if.busy, cd_if.overlay_en);
    end
  endtask

  task automatic test_start_on_tick();
    cd_if.vsync = 1'b0;
    step();
    cd_if.start = 1'b1;
    cd_if.vsync = 1'b1;
    step();
    cd_if.start = 1'b0;
    step();
    checks++;
    if (cd_if.busy !== 1'b1 || cd_if.overlay_en !== 1'b0) begin
      failures++;
      $display("FAIL start_tick_armed: busy=%b overlay_en=%b expected 1 0", cd_if.busy, cd_if.overlay_en);
    end
    do_frame();
    checks++;
    if (cd_if.overlay_en !== 1'b1 || cd_if.sprite_sel !== 2'd0) begin
      failures++;
      $display("FAIL start_tick_cnt3: overlay_en=%b sel=%0d expected 1 0", cd_if.overlay_en, cd_if.sprite_sel);
    end
  endtask

  task automatic test_async_reset();
    int fg0;
    cd_if.abort = 1'b1;
    step();
    cd_if.abort = 1'b0;
    pulse_start();
    repeat (5) do_frame();
    checks++;
    if (cd_if.sprite_sel !== 2'd1) begin
      failures++;
      $display("FAIL areset_pre_cnt2: sprite_sel=%0d expected 1", cd_if.sprite_sel);
    end
    fg0 = fg_cnt;
    @(posedge clk);
    #3 reset_n = 1'b0;
    #1;
    checks++;
    if ({cd_if.sprite_sel, cd_if.overlay_en, cd_if.busy, cd_if.fight_go, cd_if.round_active} !== 6'b0) begin
      failures++;
      $display("FAIL areset_immediate: outputs=%b expected 000000",
               {cd_if.sprite_sel, cd_if.overlay_en, cd_if.busy, cd_if.fight_go, cd_if.round_active});
    end
    repeat (2) step();
    reset_n = 1'b1;
    repeat (3) step();
    checks++;
    if (fg_cnt !== fg0 || cd_if.busy !== 1'b0) begin
      failures++;
      $display("FAIL areset_release: pulses=%0d busy=%b expected 0 0", fg_cnt - fg0, cd_if.busy);
    end
    pulse_start();
    for (int i = 1; i <= 12; i++) begin
      do_frame();
      checks++;
      if (cd_if.sprite_sel !== seq_sel[i-1]) begin
        failures++;
        $display("FAIL rerun_sel tick %0d: got %0d expected %0d", i, cd_if.sprite_sel, seq_sel[i-1]);
      end
    end
    checks++;
    if (fg_cnt !== fg0 + 1 || cd_if.round_active !== 1'b1) begin
      failures++;
      $display("FAIL rerun_fight_go: pulses=%0d round_active=%b expected 1 1", fg_cnt - fg0, cd_if.round_active);
    end
  endtask

  initial begin
    test_reset();
    test_sequence();
    test_pause();
    test_abort_restart();
    test_start_on_tick();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
